// File: rtl/shift_engine_if.sv
// Bundle of load handshake, beat control and serial/parallel outputs of shift_engine.
// A load is accepted on a rising edge where load_valid and load_ready are both high; the source may hold or drop load_valid freely.
interface shift_engine_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 1
);
  localparam int BEATS = WIDTH / LANES;
  localparam int CW    = $clog2(BEATS + 1);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             load_dir;
  logic             load_rot;
  logic             shift_en;
  logic             abort;
  logic [LANES-1:0] serial_in;
  logic [LANES-1:0] serial_out;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic             done;
  logic [CW-1:0]    beat_cnt;
  logic [1:0]       state_dbg;

  modport master (
    output load_valid, load_data, load_dir, load_rot, shift_en, abort, serial_in,
    input  load_ready, serial_out, data_out, busy, done, beat_cnt, state_dbg
  );

  modport slave (
    input  load_valid, load_data, load_dir, load_rot, shift_en, abort, serial_in,
    output load_ready, serial_out, data_out, busy, done, beat_cnt, state_dbg
  );
endinterface

// File: rtl/shift_engine.sv
// Multi-lane serialiser/deserialiser: loads a word, shifts LANES bits per beat out while
// shifting serial input (or the outgoing bits, in rotate mode) back in, then pulses done.
module shift_engine #(
  parameter int               WIDTH       = 8,
  parameter int               LANES       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic          clk,
  input  logic          rst,
  shift_engine_if.slave bus
);
  localparam int BEATS = WIDTH / LANES;
  localparam int CW    = $clog2(BEATS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             dir_q, dir_d;
  logic             rot_q, rot_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [LANES-1:0] out_bits;
  logic [LANES-1:0] in_bits;
  logic [WIDTH-1:0] shifted;
  logic             ready_c;
  logic             busy_c;
  logic             done_c;

  // dir_q=1 shifts right (LSB lanes leave first); rotate feeds the leaving lanes back in.
  assign out_bits = dir_q ? shreg_q[LANES-1:0] : shreg_q[WIDTH-1 -: LANES];
  assign in_bits  = rot_q ? out_bits : bus.serial_in;
  assign shifted  = dir_q ? {in_bits, shreg_q[WIDTH-1:LANES]}
                          : {shreg_q[WIDTH-LANES-1:0], in_bits};

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    dir_d   = dir_q;
    rot_d   = rot_q;
    cnt_d   = cnt_q;
    ready_c = 1'b0;
    busy_c  = 1'b0;
    done_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready_c = 1'b1;
      end
      S_SHIFT: begin
        busy_c = 1'b1;
        if (bus.abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (bus.shift_en) begin
          shreg_d = shifted;
          cnt_d   = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_c  = 1'b1;
        ready_c = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Accepting in DONE as well as IDLE gives bubble-free back-to-back transfers.
    if (ready_c && bus.load_valid) begin
      state_d = S_SHIFT;
      shreg_d = bus.load_data;
      dir_d   = bus.load_dir;
      rot_d   = bus.load_rot;
      cnt_d   = CW'(BEATS);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= RESET_VALUE;
      dir_q   <= 1'b0;
      rot_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      dir_q   <= dir_d;
      rot_q   <= rot_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.load_ready = ready_c;
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.serial_out = out_bits;
  assign bus.data_out   = shreg_q;
  assign bus.beat_cnt   = cnt_q;
  assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_shift_engine.sv
// Bench for shift_engine: one 1-lane and one 2-lane instance, directed scenarios then random transfers
// checked against a chunk-index model of where every lane group ends up after j beats.
module tb_shift_engine;
  logic       clk;
  logic       rst;
  logic       sel;
  logic       lv;
  logic [7:0] ld;
  logic       ldir;
  logic       lrot;
  logic       sen;
  logic       abt;
  logic [1:0] si_t;

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  shift_engine_if #(.WIDTH(8), .LANES(1)) a_if ();
  shift_engine_if #(.WIDTH(8), .LANES(2)) b_if ();

  shift_engine #(.WIDTH(8), .LANES(1), .RESET_VALUE(8'h5A)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if.slave)
  );
  shift_engine #(.WIDTH(8), .LANES(2)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if.slave)
  );

  assign a_if.load_valid = lv & ~sel;
  assign b_if.load_valid = lv & sel;
  assign a_if.load_data  = ld;
  assign b_if.load_data  = ld;
  assign a_if.load_dir   = ldir;
  assign b_if.load_dir   = ldir;
  assign a_if.load_rot   = lrot;
  assign b_if.load_rot   = lrot;
  assign a_if.shift_en   = sen;
  assign b_if.shift_en   = sen;
  assign a_if.abort      = abt;
  assign b_if.abort      = abt;
  assign a_if.serial_in  = si_t[0];
  assign b_if.serial_in  = si_t;

  logic [1:0] m_so;
  logic [7:0] m_dout;
  logic       m_ready, m_busy, m_done;
  logic [3:0] m_cnt;
  always_comb begin
    m_so    = sel ? b_if.serial_out : {1'b0, a_if.serial_out};
    m_dout  = sel ? b_if.data_out   : a_if.data_out;
    m_ready = sel ? b_if.load_ready : a_if.load_ready;
    m_busy  = sel ? b_if.busy       : a_if.busy;
    m_done  = sel ? b_if.done       : a_if.done;
    m_cnt   = sel ? {1'b0, b_if.beat_cnt} : a_if.beat_cnt;
  end

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before 400000");
    $fatal(1, "watchdog expired");
  end

  // reference model
  function automatic int chunk(input logic [7:0] w, input int c, input int l);
    return (int'(w) >> (c * l)) & ((1 << l) - 1);
  endfunction

  function automatic int out_chunk(input logic [7:0] d, input bit dr, input int l, input int m);
    int b;
    b = 8 / l;
    return dr ? chunk(d, m, l) : chunk(d, b - 1 - m, l);
  endfunction

  function automatic logic [7:0] model_word(input logic [7:0] d, input bit dr, input bit rt,
                                            input int l, input int j, input logic [1:0] si [8]);
    int b, v, m;
    logic [7:0] w;
    b = 8 / l;
    w = '0;
    for (int c = 0; c < b; c++) begin
      if (dr) begin
        if (c + j < b) v = chunk(d, c + j, l);
        else begin
          m = c + j - b;
          v = rt ? out_chunk(d, dr, l, m) : int'(si[m]);
        end
      end else begin
        if (c >= j) v = chunk(d, c - j, l);
        else begin
          m = j - 1 - c;
          v = rt ? out_chunk(d, dr, l, m) : int'(si[m]);
        end
      end
      w = w | 8'(v << (c * l));
    end
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // driver tasks
  task automatic gap(input int n);
    lv = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      abt = 1'($urandom_range(0, 1));
      sen = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("idle_ready", m_ready, 1);
      check("idle_busy", m_busy, 0);
      check("idle_done", m_done, 0);
      check("idle_cnt", m_cnt, 0);
    end
    abt = 1'b0;
  endtask

  // Called mid-cycle with the selected DUT in IDLE or DONE; returns mid-cycle after done/abort/reset.
  task automatic xfer(input bit s, input logic [7:0] d, input bit dr, input bit rt, input bit ones,
                      input int stall_at, input int stall_len, input int abort_at,
                      input int rst_at, input bit rnd_stall);
    int l, b, j, stalled, cyc;
    logic [1:0] si [8];
    logic [7:0] rv;
    bit se, do_abort, do_rst;
    sel = s;
    l = s ? 2 : 1;
    b = 8 / l;
    rv = s ? 8'h00 : 8'h5A;
    for (int k = 0; k < 8; k++)
      si[k] = ones ? 2'((1 << l) - 1) : 2'($urandom_range(0, (1 << l) - 1));
    exp_q.delete();
    for (int k = 0; k < b; k++) exp_q.push_back(8'(out_chunk(d, dr, l, k)));

    check("accept_ready", m_ready, 1);
    lv = 1'b1; ld = d; ldir = dr; lrot = rt;
    abt = 1'($urandom_range(0, 1));
    sen = 1'($urandom_range(0, 1));
    si_t = 2'($urandom_range(0, 3));
    @(posedge clk); #1;

    j = 0; stalled = 0; cyc = 0;
    while (j < b) begin
      lv = (cyc < 2);
      ld = 8'($urandom); ldir = 1'($urandom); lrot = 1'($urandom);
      do_abort = (j == abort_at);
      do_rst = (j == rst_at) && !do_abort;
      se = 1'b1;
      if (j == stall_at && stalled < stall_len) begin
        se = 1'b0; stalled++;
      end else if (rnd_stall && $urandom_range(0, 3) == 0) begin
        se = 1'b0; stalled++;
      end
      abt = do_abort; rst = do_rst; sen = se; si_t = si[j];
      @(negedge clk);
      check("beat_busy", m_busy, 1);
      check("beat_done", m_done, 0);
      check("beat_ready", m_ready, 0);
      check("beat_cnt", m_cnt, b - j);
      check("beat_serial_out", m_so, exp_q[0]);
      check("beat_data_out", m_dout, model_word(d, dr, rt, l, j, si));
      @(posedge clk); #1;
      cyc++;
      if (do_abort || do_rst) begin
        abt = 1'b0; rst = 1'b0; lv = 1'b0;
        @(negedge clk);
        check("stop_busy", m_busy, 0);
        check("stop_done", m_done, 0);
        check("stop_ready", m_ready, 1);
        check("stop_cnt", m_cnt, 0);
        check("stop_data_out", m_dout, do_rst ? rv : model_word(d, dr, rt, l, j, si));
        exp_q.delete();
        return;
      end
      if (se) begin
        j++;
        void'(exp_q.pop_front());
      end
      if (cyc > 64) begin
        check("xfer_timeout", cyc, 0);
        return;
      end
    end
    lv = 1'b0;
    @(negedge clk);
    check("end_done", m_done, 1);
    check("end_busy", m_busy, 0);
    check("end_ready", m_ready, 1);
    check("end_cnt", m_cnt, 0);
    check("end_data_out", m_dout, model_word(d, dr, rt, l, b, si));
  endtask

  // stimulus
  initial begin
    sel = 1'b0; lv = 1'b0; ld = '0; ldir = 1'b0; lrot = 1'b0;
    sen = 1'b0; abt = 1'b0; si_t = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_a_data", a_if.data_out, 8'h5A);
    check("rst_b_data", b_if.data_out, 8'h00);
    check("rst_a_ready", a_if.load_ready, 1);
    check("rst_a_busy", a_if.busy, 0);
    check("rst_a_done", a_if.done, 0);
    check("rst_a_cnt", a_if.beat_cnt, 0);
    check("rst_b_cnt", b_if.beat_cnt, 0);
    rst = 1'b0;

    // 1-lane right fill of 0xA5 with serial_in=1
    xfer(1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, -1, 0, -1, -1, 1'b0);
    check("tp1_word", m_dout, 8'hFF);
    gap(1);
    // 2-lane left rotate of 0x3C
    xfer(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, -1, 0, -1, -1, 1'b0);
    check("tp2_word", m_dout, 8'h3C);
    gap(1);
    // 3-cycle stall after beat 4, then 0x81 loaded during DONE
    xfer(1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 4, 3, -1, -1, 1'b0);
    check("tp3_word", m_dout, 8'hFF);
    xfer(1'b0, 8'h81, 1'b1, 1'b0, 1'b0, -1, 0, -1, -1, 1'b0);
    gap(1);
    // abort after beat 3 with load_valid offered in SHIFT
    xfer(1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, -1, 0, 3, -1, 1'b0);
    gap(2);
    // reset after beat 5, then a normal load
    xfer(1'b0, 8'h96, 1'b1, 1'b0, 1'b0, -1, 0, -1, 5, 1'b0);
    xfer(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, -1, 0, -1, -1, 1'b0);
    gap(1);

    for (int n = 0; n < 24; n++) begin
      bit s;
      int ab;
      s = 1'($urandom_range(0, 1));
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, s ? 3 : 7) : -1;
      xfer(s, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0, -1, 0, ab, -1, 1'b1);
      gap($urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
